// File: rtl/fifo_pkg.sv
// Lane-count helpers shared by the multi-lane FIFO and its sim-only input checks.
package fifo_pkg;

    localparam int MAX_LANES = 32;

    // Length of the unbroken run of ones starting at lane 0; lanes past a gap are ignored.
    function automatic int lane_count(input logic [MAX_LANES-1:0] vec, input int n);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n) begin
                if (run && vec[i]) cnt++;
                else               run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic logic is_thermometer(input logic [MAX_LANES-1:0] vec, input int n);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n) begin
                if (!vec[i])        seen_zero = 1'b1;
                else if (seen_zero) ok        = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/fifo_lane_count.sv
// Masked popcount of a thermometer lane vector: number of leading lanes both requested and granted.
// Purely combinational.
module fifo_lane_count #(
    parameter int LANES = 2,
    parameter int CW    = 4
) (
    input  logic [LANES-1:0] req_i,
    input  logic [LANES-1:0] grant_i,
    output logic [CW-1:0]    cnt_o
);
    import fifo_pkg::*;

    assign cnt_o = CW'(lane_count(MAX_LANES'(req_i & grant_i), LANES));

endmodule

// File: rtl/multi_port_fifo.sv
// Circular FIFO with NUM_WR push lanes and NUM_RD show-ahead pop lanes per cycle, zero pop latency.
// Optional FIFO_FLUSH_EN adds a flush_i input that empties the queue at the next edge.
module multi_port_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
`ifdef FIFO_FLUSH_EN
    input  logic                                flush_i,
`endif
    input  logic [NUM_WR-1:0]                   wr_en_i,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wr_data_i,
    output logic [NUM_WR-1:0]                   wr_ready_o,
    input  logic [NUM_RD-1:0]                   rd_en_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]                   rd_valid_o,
    output logic [ADDR_WIDTH:0]                 count_o,
    output logic [ADDR_WIDTH:0]                 free_slots_o,
    output logic                                full_o,
    output logic                                empty_o
);
    import fifo_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [CW-1:0]         free_w;
    logic [CW-1:0]         nw_w, nr_w;
    logic                  flush_w;
    logic [ADDR_WIDTH-1:0] wr_addr_w [NUM_WR];
    logic [ADDR_WIDTH-1:0] rd_addr_w [NUM_RD];
    logic [NUM_WR-1:0]     wr_fire_w;

`ifdef FIFO_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    // Ready/valid come from registered count only, so a same-cycle pop never frees a push slot.
    assign free_w = DEPTH_C - count_q;

    always_comb begin
        wr_ready_o = '0;
        wr_fire_w  = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_ready_o[i] = free_w > CW'(i);
            wr_addr_w[i]  = wptr_q + ADDR_WIDTH'(i);
            wr_fire_w[i]  = (CW'(i) < nw_w) && !flush_w;
        end
    end

    always_comb begin
        rd_valid_o = '0;
        rd_data_o  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_w[i]  = rptr_q + ADDR_WIDTH'(i);
            rd_valid_o[i] = count_q > CW'(i);
            if (rd_valid_o[i]) rd_data_o[i] = mem_q[rd_addr_w[i]];
        end
    end

    fifo_lane_count #(.LANES(NUM_WR), .CW(CW)) u_push_cnt (
        .req_i   (wr_en_i),
        .grant_i (wr_ready_o),
        .cnt_o   (nw_w)
    );

    fifo_lane_count #(.LANES(NUM_RD), .CW(CW)) u_pop_cnt (
        .req_i   (rd_en_i),
        .grant_i (rd_valid_o),
        .cnt_o   (nr_w)
    );

    always_comb begin
        wptr_d  = wptr_q + nw_w[ADDR_WIDTH-1:0];
        rptr_d  = rptr_q + nr_w[ADDR_WIDTH-1:0];
        count_d = count_q + nw_w - nr_w;
        if (flush_w) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_fire_w[i]) mem_q[wr_addr_w[i]] <= wr_data_i[i];
        end
    end

    assign count_o      = count_q;
    assign free_slots_o = free_w;
    assign full_o       = (count_q == DEPTH_C);
    assign empty_o      = (count_q == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            assert (is_thermometer(MAX_LANES'(wr_en_i), NUM_WR))
                else $warning("wr_en not thermometer coded: %b", wr_en_i);
            assert (is_thermometer(MAX_LANES'(rd_en_i), NUM_RD))
                else $warning("rd_en not thermometer coded: %b", rd_en_i);
            assert ((rd_en_i & ~rd_valid_o) == '0)
                else $warning("rd_en %b requests lanes beyond rd_valid %b", rd_en_i, rd_valid_o);
        end
    end
`endif

endmodule
